uart_rx_param: RTL and testbench

Parametrised UART receiver: the next-generation successor of the fixed 8-bit receive path in the full-duplex UART. It adds configurable data width, optional even/odd parity checking, one or two stop bits, an input synchroniser, mid-bit sampling with start-bit glitch rejection, and per-frame parity and framing error flags. It sits between the board RX GPIO and any consumer that takes a one-cycle `valid` strobe with `data`.

---
 rtl/uart_rx_param.sv | 176 +++++++++++++++++
 tb/tb_uart_rx_param.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver.
// Configurable data width (LSB first), optional even/odd parity, one or two
// stop bits, 2-flop input synchroniser, mid-bit sampling with start-bit glitch
// rejection, and per-frame parity / framing error flags delivered with a
// one-cycle valid strobe.
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 2083,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 rx_line,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam int H  = CLKS_PER_BIT / 2;

  // Counter values at which a sample is taken. The counter is 0 on the first
  // cycle of a state, so the sample lands on that state's Nth cycle.
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF  = CW'(H - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  localparam logic          PAR_ODD   = (PARITY_ODD != 0);
  localparam logic          PAR_ON    = (PARITY_EN != 0);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t state, state_nx;

  logic                 rx_meta, rx_s, rx_d;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_acc;   // running XOR of data bits
  logic                 par_bad;   // parity check result for this frame
  logic                 stop_bad;  // an earlier stop sample was low
  logic                 strobe;    // sample point in the current state
  logic                 last_stop; // final stop sample: frame complete

  // Two-flop synchroniser plus one delay flop for falling-edge detection.
  // All reset high so a reset never fabricates a start edge on an idle line.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_d    <= 1'b1;
    end else begin
      rx_meta <= rx_line;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state decode and sample strobes.
  always_comb begin
    state_nx  = state;
    strobe    = 1'b0;
    last_stop = 1'b0;
    unique case (state)
      IDLE: begin
        // Only a genuine 1->0 transition arms the receiver; a line stuck
        // low (break, or trailing a framing error) is ignored.
        if (!rx_s && rx_d) state_nx = START;
      end
      START: begin
        if (cnt == CNT_HALF) begin
          strobe   = 1'b1;
          // High at mid-start means the low pulse was a glitch.
          state_nx = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == CNT_LAST) begin
          strobe = 1'b1;
          if (bit_cnt == BIT_LAST) state_nx = PAR_ON ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (cnt == CNT_LAST) begin
          strobe   = 1'b1;
          state_nx = STOP;
        end
      end
      STOP: begin
        if (cnt == CNT_LAST) begin
          strobe = 1'b1;
          if (bit_cnt == STOP_LAST) begin
            // Return to IDLE mid-stop-bit so a back-to-back start edge
            // arriving at the end of this stop bit is still caught.
            last_stop = 1'b1;
            state_nx  = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Baud/bit counters, shift register and per-frame error accumulation.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      cnt      <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_acc  <= 1'b0;
      par_bad  <= 1'b0;
      stop_bad <= 1'b0;
    end else begin
      // Clear on every state entry and after each sample; CLKS_PER_BIT need
      // not be a power of two, so the counter never relies on wrap-around.
      if (state == IDLE || state_nx != state || strobe) cnt <= '0;
      else                                               cnt <= cnt + 1'b1;

      if (state_nx != state) bit_cnt <= '0;
      else if (strobe)       bit_cnt <= bit_cnt + 1'b1;

      if (state == START) begin
        par_acc  <= 1'b0;
        par_bad  <= 1'b0;
        stop_bad <= 1'b0;
      end

      if (strobe && state == DATA) begin
        shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
        par_acc <= par_acc ^ rx_s;
      end

      if (strobe && state == PARITY) par_bad <= ((par_acc ^ rx_s) != PAR_ODD);

      if (strobe && state == STOP) stop_bad <= stop_bad | ~rx_s;
    end
  end

  // Output registers: updated together with a one-cycle valid, one clock
  // after the final stop sample. Errored frames are still delivered.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      data       <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      valid <= last_stop;
      if (last_stop) begin
        data       <= shreg;
        parity_err <= PAR_ON & par_bad;
        frame_err  <= stop_bad | ~rx_s;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: directed self-checking bench for uart_rx_param.
// dut  : CLKS_PER_BIT=16, 8 data bits, even parity, 1 stop bit.
// dut2 : CLKS_PER_BIT=16, 7 data bits, no parity, 2 stop bits.
module tb_uart_rx_param;
  localparam int C = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       n_rst, rx_line, rx_line2;
  logic [7:0] data;
  logic       valid, parity_err, frame_err, busy;
  logic [6:0] data2;
  logic       valid2, parity_err2, frame_err2, busy2;

  int nvec = 0, nerr = 0;
  int cyc = 0, edge_cyc = 0;
  int nvalid = 0, nbusy = 0, vcyc = 0;
  int nvalid2 = 0, v2cyc = 0;
  logic [7:0] rxq[$];
  logic [7:0] got;

  uart_rx_param #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY_EN(1),
                  .PARITY_ODD(0), .STOP_BITS(1)) dut (
    .clk(clk), .n_rst(n_rst), .rx_line(rx_line), .data(data), .valid(valid),
    .parity_err(parity_err), .frame_err(frame_err), .busy(busy));

  uart_rx_param #(.CLKS_PER_BIT(C), .DATA_BITS(7), .PARITY_EN(0),
                  .PARITY_ODD(0), .STOP_BITS(2)) dut2 (
    .clk(clk), .n_rst(n_rst), .rx_line(rx_line2), .data(data2), .valid(valid2),
    .parity_err(parity_err2), .frame_err(frame_err2), .busy(busy2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample outputs on the falling edge.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (valid) begin
      nvalid++;
      vcyc = cyc;
      rxq.push_back(data);
    end
    if (busy) nbusy++;
    if (valid2) begin
      nvalid2++;
      v2cyc = cyc;
    end
  endtask

  task automatic clr();
    nvalid = 0; nbusy = 0; nvalid2 = 0;
    rxq.delete();
  endtask

  // Drive the first nb bits of a frame word, LSB first, C clocks each.
  task automatic send_bits(input logic [15:0] bits, input int nb, input bit to2);
    edge_cyc = cyc;
    for (int i = 0; i < nb; i++) begin
      if (to2) rx_line2 = bits[i];
      else     rx_line  = bits[i];
      repeat (C) tick();
    end
  endtask

  task automatic send8(input logic [7:0] d, input logic par, input logic stp);
    send_bits({5'b0, stp, par, d, 1'b0}, 11, 1'b0);
  endtask

  task automatic idle(input int n);
    rx_line  = 1'b1;
    rx_line2 = 1'b1;
    repeat (n) tick();
  endtask

  initial begin
    n_rst = 1'b0; rx_line = 1'b1; rx_line2 = 1'b1;
    repeat (3) tick();
    chk("rst_data",  data, 0);
    chk("rst_valid", valid, 0);
    chk("rst_perr",  parity_err, 0);
    chk("rst_ferr",  frame_err, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_data2", data2, 0);
    n_rst = 1'b1;
    idle(10);

    // Clean frame: latency and busy width.
    clr();
    send8(8'hA5, 1'b0, 1'b1);
    idle(20);
    chk("a5_nvalid", nvalid, 1);
    chk("a5_lat",    vcyc - edge_cyc, 171);
    chk("a5_busy",   nbusy, 168);
    chk("a5_data",   data, 8'hA5);
    chk("a5_perr",   parity_err, 0);
    chk("a5_ferr",   frame_err, 0);

    // Wrong parity bit, then a clean frame clears the flag.
    clr();
    send8(8'h3C, 1'b1, 1'b1);
    idle(20);
    chk("3c_data", data, 8'h3C);
    chk("3c_perr", parity_err, 1);
    chk("3c_ferr", frame_err, 0);
    send8(8'h01, 1'b1, 1'b1);
    idle(20);
    chk("01_data", data, 8'h01);
    chk("01_perr", parity_err, 0);
    chk("01_nvalid", nvalid, 2);

    // Stop bit low, line then held low: one delivery, no re-arm.
    clr();
    send8(8'h7E, 1'b0, 1'b0);
    rx_line = 1'b0;
    repeat (40 * C) tick();
    chk("7e_nvalid", nvalid, 1);
    chk("7e_data",   data, 8'h7E);
    chk("7e_ferr",   frame_err, 1);
    chk("7e_perr",   parity_err, 0);
    chk("7e_busy",   busy, 0);
    idle(32);
    chk("7e_nvalid_hi", nvalid, 1);

    // Short low glitch is rejected.
    clr();
    rx_line = 1'b0;
    repeat (4) tick();
    idle(40);
    chk("gl_nvalid", nvalid, 0);
    chk("gl_busy",   nbusy, 8);
    chk("gl_data",   data, 8'h7E);
    chk("gl_ferr",   frame_err, 1);

    // Back-to-back frames with no idle gap.
    clr();
    send8(8'h11, 1'b0, 1'b1);
    send8(8'h22, 1'b0, 1'b1);
    idle(20);
    chk("b2b_nvalid", nvalid, 2);
    got = 8'hxx; if (rxq.size() > 0) got = rxq[0];
    chk("b2b_w0", got, 8'h11);
    got = 8'hxx; if (rxq.size() > 1) got = rxq[1];
    chk("b2b_w1", got, 8'h22);
    chk("b2b_ferr", frame_err, 0);

    // Reset in the middle of data bit 4 of 0xF1 (bits 4..stop all high).
    clr();
    send_bits({5'b0, 1'b1, 1'b1, 8'hF1, 1'b0}, 5, 1'b0);
    rx_line = 1'b1;
    repeat (8) tick();
    chk("ra_busy_pre", busy, 1);
    n_rst = 1'b0;
    tick();
    n_rst = 1'b1;
    chk("ra_data",  data, 0);
    chk("ra_valid", valid, 0);
    chk("ra_perr",  parity_err, 0);
    chk("ra_ferr",  frame_err, 0);
    chk("ra_busy",  busy, 0);
    idle(7 + 5 * C + 40);
    chk("ra_nvalid", nvalid, 0);
    clr();
    send8(8'hC3, 1'b0, 1'b1);
    idle(20);
    chk("c3_nvalid", nvalid, 1);
    chk("c3_data",   data, 8'hC3);
    chk("c3_perr",   parity_err, 0);
    chk("c3_ferr",   frame_err, 0);

    // 7-bit, no parity, two stop bits.
    clr();
    send_bits({6'b0, 2'b11, 7'h55, 1'b0}, 10, 1'b1);
    idle(20);
    chk("d2_nvalid", nvalid2, 1);
    chk("d2_lat",    v2cyc - edge_cyc, 155);
    chk("d2_data",   data2, 7'h55);
    chk("d2_perr",   parity_err2, 0);
    chk("d2_ferr",   frame_err2, 0);
    clr();
    send_bits({6'b0, 2'b01, 7'h2A, 1'b0}, 10, 1'b1);
    idle(20);
    chk("d2s_data", data2, 7'h2A);
    chk("d2s_ferr", frame_err2, 1);
    chk("d2s_perr", parity_err2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
